// File: rtl/mult_div_seq_pkg.sv
// Shared definitions for the MULT/DIV sequencer and the control unit that drives it.
// Holds operation encoding, sequencer states, default width and the related funct codes.
package mult_div_seq_pkg;

   localparam int unsigned MULDIV_WIDTH = 32;

   typedef enum logic {
      MULDIV_OP_MULT = 1'b0,
      MULDIV_OP_DIV  = 1'b1
   } muldiv_op_t;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_ITER,
      MD_FIXUP
   } muldiv_state_t;

   localparam logic [5:0] FUNCT_MFHI = 6'h10;
   localparam logic [5:0] FUNCT_MFLO = 6'h12;
   localparam logic [5:0] FUNCT_MULT = 6'h18;
   localparam logic [5:0] FUNCT_DIV  = 6'h1A;

endpackage

// File: rtl/mult_div_seq.sv
// Multi-cycle signed MULT/DIV unit owning HI/LO: one result bit per cycle on operand
// magnitudes (shift-add multiply / restoring divide), then a sign fixup into HI/LO.
module mult_div_seq
   import mult_div_seq_pkg::*;
#(
   parameter int unsigned WIDTH = MULDIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             DivZero
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   muldiv_state_t      state, state_next;
   muldiv_op_t         op_r;
   logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
   logic [WIDTH-1:0]   opnd_b, quot_fix, rem_fix;
   logic [WIDTH:0]     add_sum, rem_sh, trial;
   logic [CW-1:0]      cnt;
   logic               neg_q, neg_r;
   logic               div_zero_req, accept, last_iter;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
   endfunction

   always_comb begin
      div_zero_req = start && (op == MULDIV_OP_DIV) && (B == '0);
      accept       = start && !div_zero_req;
      last_iter    = (cnt == CW'(WIDTH - 1));
   end

   always_comb begin
      state_next = state;
      unique case (state)
         MD_IDLE:  if (accept) state_next = MD_ITER;
         MD_ITER:  if (last_iter) state_next = MD_FIXUP;
         MD_FIXUP: state_next = MD_IDLE;
         default:  state_next = MD_IDLE;
      endcase
   end

   // acc low half holds the multiplier (MULT) or dividend/quotient (DIV); high half is the
   // running partial product or partial remainder.
   always_comb begin
      add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd_b};
      rem_sh   = acc[2*WIDTH-1:WIDTH-1];
      trial    = rem_sh - {1'b0, opnd_b};
      acc_step = acc;
      if (op_r == MULDIV_OP_MULT) begin
         if (acc[0]) acc_step = {add_sum, acc[WIDTH-1:1]};
         else        acc_step = {1'b0, acc[2*WIDTH-1:1]};
      end else begin
         if (!trial[WIDTH]) acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else               acc_step = {acc[2*WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      prod_fix = neg_q ? (~acc + (2*WIDTH)'(1)) : acc;
      quot_fix = neg_q ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
      rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) state <= MD_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc     <= '0;
         opnd_b  <= '0;
         cnt     <= '0;
         op_r    <= MULDIV_OP_MULT;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         HI      <= '0;
         LO      <= '0;
         DivZero <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            MD_IDLE: begin
               if (div_zero_req) begin
                  done    <= 1'b1;
                  DivZero <= 1'b1;
               end else if (accept) begin
                  acc     <= {{WIDTH{1'b0}}, mag(A)};
                  opnd_b  <= mag(B);
                  op_r    <= muldiv_op_t'(op);
                  neg_q   <= A[WIDTH-1] ^ B[WIDTH-1];
                  neg_r   <= A[WIDTH-1];
                  cnt     <= '0;
                  busy    <= 1'b1;
                  DivZero <= 1'b0;
               end
            end
            MD_ITER: begin
               acc <= acc_step;
               cnt <= cnt + CW'(1);
            end
            MD_FIXUP: begin
               if (op_r == MULDIV_OP_MULT) begin
                  HI <= prod_fix[2*WIDTH-1:WIDTH];
                  LO <= prod_fix[WIDTH-1:0];
               end else begin
                  HI <= rem_fix;
                  LO <= quot_fix;
               end
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
